fetch_queue: RTL and testbench

Decoupling FIFO between the instruction-fetch stage and the decode stage of the pipelined RV32I core. It captures {pc, instruction} pairs as the I-cache returns them and presents them in order to decode, absorbing decode stalls without stalling the PC register. A single-cycle `flush` discards all queued instructions on a taken branch or jump redirect.

---
 rtl/rv32i_packet.sv | 21 ++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_packet.sv
`default_nettype none
// ============================================================================
// Package     : rv32i_packet
// Description : Shared RV32I pipeline types. fetch_entry_t is the
//               {pc, instruction} pair carried from fetch to decode through
//               fetch_queue. Decode builds its rv32i_packet_t from it.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_packet;

    localparam int RV32I_XLEN = 32;

    typedef logic [RV32I_XLEN-1:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instruction;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : In-order decoupling FIFO between instruction fetch and
//               decode. It holds {pc, instruction} pairs returned by the
//               I-cache and lets decode stall without stalling the PC.
//               A single-cycle flush empties the queue on a redirect.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               flush        - drop all entries and any same-cycle enqueue
//               enq_valid/enq_ready/enq_pc/enq_inst - fetch-side handshake
//               deq_valid/deq_ready/deq_pc/deq_inst - decode-side handshake
//               count        - current occupancy (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import rv32i_packet::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  rv32i_word                  enq_pc,
    input  rv32i_word                  enq_inst,
    output logic                       enq_ready,
    output logic                       deq_valid,
    output rv32i_word                  deq_pc,
    output rv32i_word                  deq_inst,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Storage is deliberately not reset; only pointers and count are.
    fetch_entry_t       mem_q [DEPTH];

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               enq_fire;
    logic               deq_fire;
    fetch_entry_t       head_entry;

    // Ready/valid come from registered count only, so there is no
    // combinational path from deq_ready to enq_ready. A full queue
    // therefore refuses an enqueue even if decode dequeues that cycle.
    assign enq_ready = (count_q != FULL_COUNT);
    assign deq_valid = (count_q != '0);

    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign deq_fire  = deq_valid && deq_ready && !flush;

    assign head_entry = mem_q[head_q];
    assign deq_pc     = deq_valid ? head_entry.pc          : '0;
    assign deq_inst   = deq_valid ? head_entry.instruction : '0;
    assign count      = count_q;

    // Pointers are exactly PTR_W bits wide so they wrap modulo DEPTH
    // without explicit compare logic (DEPTH is a power of two).
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq_fire) begin
                head_d = head_q + PTR_W'(1);
            end
            unique case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Writes are gated by rst as well so a reset-cycle enqueue leaves no trace.
    always_ff @(posedge clk) begin
        if (enq_fire && !rst) begin
            mem_q[tail_q] <= '{pc: enq_pc, instruction: enq_inst};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic [31:0] enq_inst;
    logic        enq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic        deq_ready;
    logic [2:0]  count;

    int checks;
    int errors;

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_inst  (enq_inst),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_inst  (deq_inst),
        .deq_ready (deq_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word tied to its pc so every entry is distinguishable.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ (pc << 4) ^ 32'h13;
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        enq_valid = 1'b1;
        enq_pc    = pc;
        enq_inst  = inst_of(pc);
    endtask

    task automatic idle();
        enq_valid = 1'b0;
        enq_pc    = '0;
        enq_inst  = '0;
        deq_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid got %b want 0", deq_valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got %b want 1", enq_ready); end
        checks++; if (deq_pc !== 32'h0) begin errors++; $display("FAIL reset_deq_pc got %h want 0", deq_pc); end
        checks++; if (deq_inst !== 32'h0) begin errors++; $display("FAIL reset_deq_inst got %h want 0", deq_inst); end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %b want 1", i, enq_ready); end
            offer(32'h60 + 32'(4 * i));
            tick();
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
        end
        idle();
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_enq_ready got %b want 0", enq_ready); end
        checks++; if (deq_pc !== 32'h60) begin errors++; $display("FAIL full_head_pc got %h want 60", deq_pc); end
        // Fifth offer while full must be refused.
        offer(32'h70);
        tick();
        idle();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fifth_offer_count got %0d want 4", count); end
        checks++; if (deq_pc !== 32'h60) begin errors++; $display("FAIL fifth_offer_head got %h want 60", deq_pc); end
    endtask

    task automatic test_drain();
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b want 1", i, deq_valid); end
            checks++; if (deq_pc !== 32'h60 + 32'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d] got %h want %h", i, deq_pc, 32'h60 + 32'(4 * i)); end
            checks++; if (deq_inst !== inst_of(32'h60 + 32'(4 * i))) begin errors++; $display("FAIL drain_inst[%0d] got %h want %h", i, deq_inst, inst_of(32'h60 + 32'(4 * i))); end
            tick();
        end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL drained_valid got %b want 0", deq_valid); end
        checks++; if (deq_pc !== 32'h0) begin errors++; $display("FAIL drained_pc got %h want 0", deq_pc); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drained_count got %0d want 0", count); end
        idle();
    endtask

    task automatic test_stream();
        // Starts empty: cycle 0 has enq and deq together, only enq fires.
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                checks++; if (deq_pc !== 32'h100 + 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", k, deq_pc, 32'h100 + 32'(4 * (k - 1))); end
                checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d want 1", k, count); end
            end
            offer(32'h100 + 32'(4 * k));
            deq_ready = 1'b1;
            tick();
        end
        enq_valid = 1'b0;
        checks++; if (deq_pc !== 32'h124) begin errors++; $display("FAIL stream_last_pc got %h want 124", deq_pc); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_last_count got %0d want 1", count); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_end_count got %0d want 0", count); end
        idle();
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) begin
            offer(32'h400 + 32'(4 * i));
            tick();
        end
        offer(32'h500);
        deq_ready = 1'b1;
        tick();
        idle();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_simul_count got %0d want 3", count); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL full_simul_ready got %b want 1", enq_ready); end
        deq_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++; if (deq_pc !== 32'h400 + 32'(4 * i)) begin errors++; $display("FAIL full_simul_pc[%0d] got %h want %h", i, deq_pc, 32'h400 + 32'(4 * i)); end
            tick();
        end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL full_simul_not_written got valid=%b pc=%h want valid=0", deq_valid, deq_pc); end
        idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            offer(32'h800 + 32'(4 * i));
            tick();
        end
        flush     = 1'b1;
        offer(32'h200);
        deq_ready = 1'b1;
        tick();
        idle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL flush_deq_valid got %b want 0", deq_valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL flush_enq_ready got %b want 1", enq_ready); end
        offer(32'h300);
        tick();
        idle();
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 32'h300) begin errors++; $display("FAIL flush_next_head got valid=%b pc=%h want 1/300", deq_valid, deq_pc); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_next_count got %0d want 1", count); end
        // Flush while holding one more entry -> fill to full, then flush.
        for (int i = 0; i < 3; i++) begin
            offer(32'hC00 + 32'(4 * i));
            tick();
        end
        idle();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL flush_full_pre got %0d want 4", count); end
        flush = 1'b1;
        tick();
        idle();
        checks++; if (count !== 3'd0 || enq_ready !== 1'b1) begin errors++; $display("FAIL flush_full got count=%0d ready=%b want 0/1", count, enq_ready); end
        // Flush while empty stays empty.
        flush = 1'b1;
        tick();
        idle();
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got count=%0d valid=%b want 0/0", count, deq_valid); end
    endtask

    task automatic test_reset_mid();
        offer(32'h900);
        tick();
        offer(32'h904);
        tick();
        rst = 1'b1;
        offer(32'h908);
        tick();
        rst = 1'b0;
        idle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_mid_count got %0d want 0", count); end
        checks++; if (deq_inst !== 32'h0) begin errors++; $display("FAIL rst_mid_inst got %h want 0", deq_inst); end
        deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale[%0d] got valid=%b pc=%h want 0", i, deq_valid, deq_pc); end
            tick();
        end
        idle();
        offer(32'hA00);
        tick();
        idle();
        checks++; if (deq_pc !== 32'hA00 || count !== 3'd1) begin errors++; $display("FAIL rst_mid_fresh got pc=%h count=%0d want a00/1", deq_pc, count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_full_simul();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
